mem_port_arbiter: RTL and testbench

- Shares the core's single unified memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the fetch and LSU stages and the memory/bus interface.
- Fixed priority favours data accesses, with a bounded-starvation guarantee for fetch.
- Supports one outstanding transaction, a request/grant/response handshake, and discard of in-flight fetch responses on redirect.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (read-only) and
// load/store. Data accesses win by default; fetch wins once the LSU has taken
// STARVE_LIMIT consecutive grants while fetch was waiting. One outstanding
// transaction; fetch responses can be discarded on redirect.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // load/store side
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  // memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_I,
    WAIT_D,
    WAIT_X
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       lock_q, lock_d;
  logic       lock_ls_q, lock_ls_d;
  logic [3:0] streak_q, streak_d;

  logic sel_ls;
  logic owner_req;

  // Owner selection: a pending lock pins the owner so an unaccepted request
  // cannot be switched mid-handshake.
  always_comb begin
    sel_ls = 1'b0;
    if (lock_q) begin
      sel_ls = lock_ls_q;
    end else if (if_req && ls_req) begin
      sel_ls = (streak_q != LIMIT);
    end else begin
      sel_ls = ls_req;
    end
    owner_req = sel_ls ? ls_req : if_req;
  end

  assign mem_req   = ~rst & (state_q == IDLE) & owner_req;
  assign mem_we    = sel_ls & ls_we;
  assign mem_addr  = sel_ls ? ls_addr : if_addr;
  assign mem_wdata = sel_ls ? ls_wdata : '0;
  assign mem_wstrb = sel_ls ? ls_wstrb : '0;

  assign if_gnt    = mem_req & mem_gnt & ~sel_ls;
  assign ls_gnt    = mem_req & mem_gnt & sel_ls;

  assign if_rvalid = ~rst & (state_q == WAIT_I) & mem_rvalid & ~if_flush;
  assign ls_rvalid = ~rst & (state_q == WAIT_D) & mem_rvalid;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

  // Next-state, lock and starvation-streak computation.
  always_comb begin
    state_d   = state_q;
    // Lock holds exactly while the owner requests without being accepted;
    // a grant or a dropped request both clear it.
    lock_d    = mem_req & ~mem_gnt;
    lock_ls_d = sel_ls;
    streak_d  = streak_q;

    if (ls_gnt) begin
      if (if_req) begin
        streak_d = (streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1;
      end else begin
        streak_d = '0;
      end
    end else if (if_gnt) begin
      streak_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (ls_gnt) begin
          state_d = WAIT_D;
        end else if (if_gnt) begin
          state_d = if_flush ? WAIT_X : WAIT_I;
        end
      end
      WAIT_I: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end else if (if_flush) begin
          state_d = WAIT_X;
        end
      end
      WAIT_D: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      WAIT_X: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_q    <= 1'b0;
      lock_ls_q <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      lock_ls_q <= lock_ls_d;
      streak_q  <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled mid-cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req     = 1'b0;
    if_flush   = 1'b0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b00000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
    end
    idle_in(); rst = 1'b0; mem_rvalid = 1'b1; #4;
    total++;
    if ({if_rvalid, ls_rvalid, mem_req} !== 3'b000) begin
      bad++; $display("FAIL idle_rvalid_ignored got=%b exp=000", {if_rvalid, ls_rvalid, mem_req});
    end
    cyc(); idle_in();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1; #4;
    total++;
    if ({mem_req, mem_we, if_gnt, ls_gnt} !== 4'b1010) begin
      bad++; $display("FAIL fetch_grant got=%b exp=1010", {mem_req, mem_we, if_gnt, ls_gnt});
    end
    total++;
    if ({mem_addr, mem_wstrb} !== {32'h100, 4'h0}) begin
      bad++; $display("FAIL fetch_payload got=%h/%h exp=00000100/0", mem_addr, mem_wstrb);
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; #4;
    total++;
    if ({mem_req, if_gnt, if_rvalid} !== 3'b000) begin
      bad++; $display("FAIL fetch_wait got=%b exp=000", {mem_req, if_gnt, if_rvalid});
    end
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h13; if_req = 1'b1; if_addr = 32'h104; mem_gnt = 1'b1; #4;
    total++;
    if ({if_rvalid, ls_rvalid, if_gnt, mem_req} !== 4'b1000) begin
      bad++; $display("FAIL fetch_resp got=%b exp=1000", {if_rvalid, ls_rvalid, if_gnt, mem_req});
    end
    total++;
    if (if_rdata !== 32'h13) begin
      bad++; $display("FAIL fetch_rdata got=%h exp=00000013", if_rdata);
    end
    cyc(); idle_in();
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h180;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_wstrb = 4'hF;
    mem_gnt = 1'b1; #4;
    total++;
    if ({ls_gnt, if_gnt, mem_we} !== 3'b101) begin
      bad++; $display("FAIL prio_lsu_first got=%b exp=101", {ls_gnt, if_gnt, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h2000, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL prio_store_payload got=%h/%h/%h exp=00002000/deadbeef/f", mem_addr, mem_wdata, mem_wstrb);
    end
    cyc(); ls_req = 1'b0; ls_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; #4;
    total++;
    if ({ls_rvalid, mem_req, if_gnt} !== 3'b100) begin
      bad++; $display("FAIL prio_store_ack got=%b exp=100", {ls_rvalid, mem_req, if_gnt});
    end
    cyc(); mem_rvalid = 1'b0; mem_gnt = 1'b1; #4;
    total++;
    if ({if_gnt, ls_gnt, mem_we, mem_wstrb, mem_addr} !== {3'b100, 4'h0, 32'h180}) begin
      bad++; $display("FAIL prio_ifu_next got=%b/%h/%h exp=100/0/00000180", {if_gnt, ls_gnt, mem_we}, mem_wstrb, mem_addr);
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #4;
    total++;
    if ({if_rvalid, ls_rvalid} !== 2'b10) begin
      bad++; $display("FAIL prio_ifu_resp got=%b exp=10", {if_rvalid, ls_rvalid});
    end
    cyc(); idle_in();
  endtask

  task automatic test_starvation();
    logic [6:0] order;
    order = 7'b1101111;  // bit i = 1 when grant i goes to LSU: D D D D I D D
    for (int i = 0; i < 7; i++) begin
      if_req = 1'b1; if_addr = 32'h200;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000 + 32'(i * 4);
      mem_gnt = 1'b1; mem_rvalid = 1'b0; #4;
      total++;
      if ({ls_gnt, if_gnt} !== {order[i], ~order[i]}) begin
        bad++; $display("FAIL starve_grant idx=%0d got ls/if=%b exp=%b", i, {ls_gnt, if_gnt}, {order[i], ~order[i]});
      end
      cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #4;
      if (i == 4) begin
        total++;
        if (dut.streak_q !== 4'd0) begin
          bad++; $display("FAIL starve_streak_clear got=%0d exp=0", dut.streak_q);
        end
      end
      cyc(); mem_rvalid = 1'b0;
    end
    idle_in();
  endtask

  task automatic test_lock();
    if_req = 1'b1; if_addr = 32'h300; mem_gnt = 1'b0; #4;
    total++;
    if ({mem_req, mem_addr, if_gnt} !== {1'b1, 32'h300, 1'b0}) begin
      bad++; $display("FAIL lock_first got=%b/%h/%b exp=1/00000300/0", mem_req, mem_addr, if_gnt);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; #4;
      total++;
      if ({mem_addr, mem_we, ls_gnt, if_gnt} !== {32'h300, 3'b000}) begin
        bad++; $display("FAIL lock_hold k=%0d got=%h/%b exp=00000300/000", k, mem_addr, {mem_we, ls_gnt, if_gnt});
      end
    end
    cyc(); mem_gnt = 1'b1; #4;
    total++;
    if ({if_gnt, ls_gnt} !== 2'b10) begin
      bad++; $display("FAIL lock_ifu_gnt got=%b exp=10", {if_gnt, ls_gnt});
    end
    cyc(); if_req = 1'b0; #4;
    total++;
    if ({mem_req, ls_gnt} !== 2'b00) begin
      bad++; $display("FAIL lock_wait_no_issue got=%b exp=00", {mem_req, ls_gnt});
    end
    cyc(); mem_rvalid = 1'b1; mem_rdata = 32'h99; #4;
    total++;
    if ({if_rvalid, ls_gnt, mem_req} !== 3'b100) begin
      bad++; $display("FAIL lock_resp_no_issue got=%b exp=100", {if_rvalid, ls_gnt, mem_req});
    end
    cyc(); mem_rvalid = 1'b0; #4;
    total++;
    if ({ls_gnt, if_gnt, mem_addr} !== {2'b10, 32'h400}) begin
      bad++; $display("FAIL lock_lsu_after got=%b/%h exp=10/00000400", {ls_gnt, if_gnt}, mem_addr);
    end
    cyc(); ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAB; #4;
    total++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'hAB}) begin
      bad++; $display("FAIL lock_lsu_resp got=%b/%h exp=1/000000ab", ls_rvalid, ls_rdata);
    end
    cyc(); idle_in();
  endtask

  task automatic test_flush();
    // flush while waiting, response arrives later
    if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1; #4;
    total++;
    if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL flushA_gnt got=%b exp=1", if_gnt);
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; if_flush = 1'b1; #4;
    total++;
    if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL flushA_wait got=%b exp=0", if_rvalid);
    end
    cyc(); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11; #4;
    total++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      bad++; $display("FAIL flushA_discard got=%b exp=00", {if_rvalid, ls_rvalid});
    end
    cyc(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h600; mem_gnt = 1'b1; #4;
    total++;
    if ({mem_req, if_gnt, mem_addr} !== {2'b11, 32'h600}) begin
      bad++; $display("FAIL flushA_idle got=%b/%h exp=11/00000600", {mem_req, if_gnt}, mem_addr);
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; #4;
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h77}) begin
      bad++; $display("FAIL flushA_next got=%b/%h exp=1/00000077", if_rvalid, if_rdata);
    end
    // flush in the same cycle as the response
    cyc(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h700; mem_gnt = 1'b1; #4;
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; if_flush = 1'b1; mem_rdata = 32'h22; #4;
    total++;
    if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL flushB_same_cycle got=%b exp=0", if_rvalid);
    end
    // flush alone in IDLE must not disturb the following fetch
    cyc(); mem_rvalid = 1'b0; if_flush = 1'b1; #4;
    cyc(); if_flush = 1'b0; if_req = 1'b1; if_addr = 32'h800; mem_gnt = 1'b1; #4;
    total++;
    if ({mem_req, if_gnt} !== 2'b11) begin
      bad++; $display("FAIL flushB_idle got=%b exp=11", {mem_req, if_gnt});
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88; #4;
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h88}) begin
      bad++; $display("FAIL flushB_next got=%b/%h exp=1/00000088", if_rvalid, if_rdata);
    end
    // flush in the grant cycle
    cyc(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h900; mem_gnt = 1'b1; if_flush = 1'b1; #4;
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; if_flush = 1'b0; mem_rvalid = 1'b1; #4;
    total++;
    if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL flushC_grant_cycle got=%b exp=0", if_rvalid);
    end
    cyc(); idle_in();
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4000; mem_gnt = 1'b1; #4;
    total++;
    if (ls_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_gnt got=%b exp=1", ls_gnt);
    end
    cyc(); if_req = 1'b1; mem_rvalid = 1'b1; rst = 1'b1; #1;
    total++;
    if ({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b00000) begin
      bad++; $display("FAIL rstmid_outputs got=%b exp=00000", {mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid});
    end
    #1; if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0; rst = 1'b0; #2;
    total++;
    if ({ls_rvalid, if_rvalid, mem_req} !== 3'b000) begin
      bad++; $display("FAIL rstmid_abandon got=%b exp=000", {ls_rvalid, if_rvalid, mem_req});
    end
    cyc(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'hA00; mem_gnt = 1'b1; #4;
    total++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'hA00}) begin
      bad++; $display("FAIL rstmid_fetch_gnt got=%b/%h exp=1/00000a00", if_gnt, mem_addr);
    end
    cyc(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #4;
    total++;
    if ({if_rvalid, if_rdata, ls_rvalid} !== {1'b1, 32'h1234, 1'b0}) begin
      bad++; $display("FAIL rstmid_fetch_resp got=%b/%h/%b exp=1/00001234/0", if_rvalid, if_rdata, ls_rvalid);
    end
    cyc(); idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1'b1; if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_lock();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
